// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the pipeline MEM stage and a program/data loader.
// The CPU has priority, the loader gets a slot after STARVE_MAX denied cycles, and boot hands the loader exclusive ownership.
module dmem_arbiter #(
    parameter int AW         = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [31:0]   ld_addr,
    input  logic [31:0]   ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [31:0]   ld_rdata,
    input  logic          boot,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          misalign_err
);
    localparam int SW = (STARVE_MAX < 3) ? 2 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_LD   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          rd_q, rd_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          misalign_q, misalign_d;

    logic          cpu_gnt;
    logic          g_we;
    logic [31:0]   g_addr;
    logic [31:0]   g_wdata;
    logic          misaligned;
    logic          unused_addr_bits;

    always_comb begin
        cpu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        if (!rst) begin
            if (boot)
                ld_gnt = ld_req;
            else if (ld_req && (starve_q >= STARVE_LIM))
                ld_gnt = 1'b1;
            else if (cpu_req)
                cpu_gnt = 1'b1;
            else if (ld_req)
                ld_gnt = 1'b1;
        end
    end

    always_comb begin
        g_we    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        if (cpu_gnt) begin
            g_we    = cpu_we;
            g_addr  = cpu_addr;
            g_wdata = cpu_wdata;
        end else if (ld_gnt) begin
            g_we    = ld_we;
            g_addr  = ld_addr;
            g_wdata = ld_wdata;
        end
    end

    assign misaligned       = (cpu_gnt | ld_gnt) && (g_addr[1:0] != 2'b00);
    assign unused_addr_bits = ^g_addr[31:AW+2];

    // A misaligned write is dropped; a misaligned read still goes out on the word address.
    assign mem_en    = cpu_gnt | ld_gnt;
    assign mem_we    = g_we & ~misaligned;
    assign mem_addr  = g_addr[AW+1:2];
    assign mem_wdata = g_wdata;

    assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;

    always_comb begin
        state_d    = ST_IDLE;
        if (cpu_gnt)
            state_d = ST_CPU;
        else if (ld_gnt)
            state_d = ST_LD;
        rd_d       = mem_en & ~g_we;
        misalign_d = misalign_q | misaligned;
        starve_d   = '0;
        if (ld_req && !ld_gnt)
            starve_d = (starve_q == '1) ? starve_q : starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_q       <= 1'b0;
            starve_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            starve_q   <= starve_d;
            misalign_q <= misalign_d;
        end
    end

    // Return routing follows the owner recorded last cycle, so a boot change cannot misdirect it.
    assign cpu_rvalid   = (state_q == ST_CPU) & rd_q;
    assign ld_rvalid    = (state_q == ST_LD) & rd_q;
    assign cpu_rdata    = cpu_rvalid ? mem_rdata : 32'd0;
    assign ld_rdata     = ld_rvalid ? mem_rdata : 32'd0;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected reads/writes, a negedge monitor retires them.
module tb_dmem_arbiter;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [31:0]   cpu_addr, cpu_wdata;
    logic          cpu_stall, cpu_rvalid;
    logic [31:0]   cpu_rdata;
    logic          ld_req, ld_we;
    logic [31:0]   ld_addr, ld_wdata;
    logic          ld_gnt, ld_rvalid;
    logic [31:0]   ld_rdata;
    logic          boot;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'd0;
    logic          misalign_err;

    always #50 clk = ~clk;

    dmem_arbiter #(.AW(AW), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .boot(boot),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .misalign_err(misalign_err)
    );

    logic [31:0] mem_model [0:255];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                mem_model[mem_addr] <= mem_wdata;
            else
                mem_rdata <= mem_model[mem_addr];
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] cpu_exp_q [$];
    logic [31:0] ld_exp_q [$];
    logic [39:0] wr_exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: actual=event required=none", name);
    endtask

    // Monitor: retires read returns and memory writes against the queued expectations.
    always @(negedge clk) begin
        logic [31:0] e;
        logic [39:0] w;
        if (rst !== 1'b1) begin
            chk("rvalid_exclusive", 32'(cpu_rvalid & ld_rvalid), 32'd0);
            if (cpu_rvalid) begin
                if (cpu_exp_q.size() == 0) unexpected("cpu_rvalid");
                else begin
                    e = cpu_exp_q.pop_front();
                    chk("cpu_rdata", cpu_rdata, e);
                    $display("t=%0t cpu read return rdata=0x%08h", $time, cpu_rdata);
                end
            end
            if (ld_rvalid) begin
                if (ld_exp_q.size() == 0) unexpected("ld_rvalid");
                else begin
                    e = ld_exp_q.pop_front();
                    chk("ld_rdata", ld_rdata, e);
                    $display("t=%0t ld read return rdata=0x%08h", $time, ld_rdata);
                end
            end
            if (mem_en && mem_we) begin
                if (wr_exp_q.size() == 0) unexpected("mem_write");
                else begin
                    w = wr_exp_q.pop_front();
                    chk("mem_waddr", 32'(mem_addr), 32'(w[39:32]));
                    chk("mem_wdata", mem_wdata, w[31:0]);
                    $display("t=%0t mem write addr=%0d data=0x%08h", $time, mem_addr, mem_wdata);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic ld_set(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        ld_req = r; ld_we = w; ld_addr = a; ld_wdata = d;
    endtask

    initial begin
        bit ldw;
        for (int i = 0; i < 256; i++) mem_model[i] = 32'd0;
        mem_model[4] = 32'hDEADBEEF;
        rst  = 1'b1;
        boot = 1'b0;
        cpu_set(1'b1, 1'b0, 32'h10, 32'd0);
        ld_set(1'b1, 1'b0, 32'h20, 32'd0);

        // Reset: grants forced off before and after the first edge.
        #20;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_ld_gnt", 32'(ld_gnt), 32'd0);
        next_cycle();
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_ld_rdata", ld_rdata, 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        chk("rst_mem_en_edge", 32'(mem_en), 32'd0);
        next_cycle();
        rst = 1'b0;
        cpu_set(1'b0, 1'b0, 32'd0, 32'd0);
        ld_set(1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();

        // CPU read of word 4.
        cpu_set(1'b1, 1'b0, 32'h10, 32'd0);
        cpu_exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("cpu_rd_mem_en", 32'(mem_en), 32'd1);
        chk("cpu_rd_mem_addr", 32'(mem_addr), 32'd4);
        chk("cpu_rd_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        cpu_set(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("cpu_rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("cpu_rd_ld_rvalid", 32'(ld_rvalid), 32'd0);
        next_cycle();

        // Write/read-back from each requester.
        cpu_set(1'b1, 1'b1, 32'h20, 32'h12345678);
        wr_exp_q.push_back({8'h08, 32'h12345678});
        @(negedge clk);
        chk("cpu_wr_mem_we", 32'(mem_we), 32'd1);
        next_cycle();
        cpu_set(1'b1, 1'b0, 32'h20, 32'd0);
        cpu_exp_q.push_back(32'h12345678);
        next_cycle();
        cpu_set(1'b0, 1'b0, 32'd0, 32'd0);
        ld_set(1'b1, 1'b1, 32'h24, 32'hA5A50001);
        wr_exp_q.push_back({8'h09, 32'hA5A50001});
        @(negedge clk);
        chk("ld_wr_gnt", 32'(ld_gnt), 32'd1);
        next_cycle();
        ld_set(1'b1, 1'b0, 32'h24, 32'd0);
        ld_exp_q.push_back(32'hA5A50001);
        next_cycle();
        ld_set(1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();

        // Both requesting: CPU three cycles, loader every fourth.
        cpu_set(1'b1, 1'b0, 32'h10, 32'd0);
        ld_set(1'b1, 1'b0, 32'h20, 32'd0);
        for (int k = 0; k < 10; k++) begin
            ldw = ((k % 4) == 3);
            if (ldw) ld_exp_q.push_back(32'h12345678);
            else     cpu_exp_q.push_back(32'hDEADBEEF);
            @(negedge clk);
            chk($sformatf("starve_ld_gnt_%0d", k), 32'(ld_gnt), 32'(ldw));
            chk($sformatf("starve_cpu_stall_%0d", k), 32'(cpu_stall), 32'(ldw));
            next_cycle();
        end
        cpu_set(1'b0, 1'b0, 32'd0, 32'd0);
        ld_set(1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();

        // Boot: loader owns memory while the CPU keeps requesting.
        boot = 1'b1;
        cpu_set(1'b1, 1'b0, 32'h10, 32'd0);
        for (int i = 0; i < 4; i++) begin
            ld_set(1'b1, 1'b1, 32'(i * 4), 32'(i + 1));
            wr_exp_q.push_back({8'(i), 32'(i + 1)});
            @(negedge clk);
            chk($sformatf("boot_ld_gnt_%0d", i), 32'(ld_gnt), 32'd1);
            chk($sformatf("boot_cpu_stall_%0d", i), 32'(cpu_stall), 32'd1);
            next_cycle();
        end
        ld_set(1'b1, 1'b0, 32'h0C, 32'd0);
        ld_exp_q.push_back(32'd4);
        @(negedge clk);
        chk("boot_rd_cpu_stall", 32'(cpu_stall), 32'd1);
        next_cycle();
        // Boot drops: CPU granted at once while the loader's read return lands.
        boot = 1'b0;
        ld_set(1'b0, 1'b0, 32'd0, 32'd0);
        cpu_exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("unboot_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("unboot_ld_rvalid", 32'(ld_rvalid), 32'd1);
        next_cycle();
        cpu_set(1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();

        // Misaligned write is suppressed and the error flag sticks.
        cpu_set(1'b1, 1'b1, 32'h13, 32'hFFFFFFFF);
        @(negedge clk);
        chk("mis_mem_en", 32'(mem_en), 32'd1);
        chk("mis_mem_we", 32'(mem_we), 32'd0);
        chk("mis_mem_addr", 32'(mem_addr), 32'd4);
        chk("mis_err_same_cycle", 32'(misalign_err), 32'd0);
        next_cycle();
        cpu_set(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("mis_err_set", 32'(misalign_err), 32'd1);
        next_cycle();
        cpu_set(1'b1, 1'b0, 32'h11, 32'd0);
        cpu_exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("mis_rd_mem_addr", 32'(mem_addr), 32'd4);
        next_cycle();
        cpu_set(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("mis_err_sticky", 32'(misalign_err), 32'd1);
        next_cycle();

        // Loader read followed immediately by reset: return is discarded.
        ld_set(1'b1, 1'b0, 32'h0, 32'd0);
        @(negedge clk);
        chk("pre_rst_ld_gnt", 32'(ld_gnt), 32'd1);
        next_cycle();
        ld_set(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("in_rst_mem_en", 32'(mem_en), 32'd0);
        next_cycle();
        chk("post_rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
        chk("post_rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("post_rst_misalign", 32'(misalign_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
        next_cycle();

        chk("cpu_queue_drained", 32'(cpu_exp_q.size()), 32'd0);
        chk("ld_queue_drained", 32'(ld_exp_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("boot_word_%0d", i), mem_model[i], 32'(i + 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: AW, 8, memory word-address width; mem_addr = req_addr[AW+1:2].
REQ-002 Parameter: STARVE_MAX, 3, consecutive denied loader cycles before the loader is forced a slot.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  pipeline MEM stage requests an access this cycle.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  32  byte address from the MEM stage.
REQ-008 cpu_wdata  input  32  write data from the MEM stage.
REQ-009 cpu_stall  output  1  combinational; cpu_req high and not granted this cycle.
REQ-010 cpu_rvalid  output  1  registered; cpu_rdata valid this cycle.
REQ-011 cpu_rdata  output  32  read data returned to the MEM/WB stage.
REQ-012 ld_req, ld_we  input  1 each  program/data loader request and write enable.
REQ-013 ld_addr, ld_wdata  input  32 each  loader byte address and write data.
REQ-014 ld_gnt  output  1  combinational; loader access issued this cycle.
REQ-015 ld_rvalid  output  1  registered; ld_rdata valid this cycle.
REQ-016 ld_rdata  output  32  read data returned to the loader.
REQ-017 boot  input  1  loader owns memory exclusively; the CPU is never granted.
REQ-018 mem_en, mem_we  output  1 each  memory enable and write strobe.
REQ-019 mem_addr  output  AW  memory word address.
REQ-020 mem_wdata  output  32  memory write data.
REQ-021 mem_rdata  input  32  synchronous memory read data, valid one cycle after a read issue.
REQ-022 misalign_err  output  1  sticky flag; a granted access had addr[1:0] != 0.

Function
REQ-023 At most one access SHALL be issued per cycle; mem_en = cpu_gnt | ld_gnt, where cpu_gnt is internal.
REQ-024 The FSM SHALL have states IDLE, CPU and LD, recording the owner of the previous cycle's issued access; IDLE when nothing was issued.
REQ-025 Grant rule: boot=1 -> ld_gnt = ld_req and cpu_gnt = 0.
REQ-026 Grant rule: starve_cnt >= STARVE_MAX and ld_req -> ld_gnt = 1.
REQ-027 Grant rule: otherwise cpu_req -> cpu_gnt = 1.
REQ-028 Grant rule: otherwise ld_req -> ld_gnt = 1.
REQ-029 starve_cnt (2+ bits, saturating) SHALL increment each cycle ld_req is high and ld_gnt is low, and clear when ld_gnt is high or ld_req is low.
REQ-030 mem_we, mem_addr and mem_wdata SHALL be muxed from the granted requester; when idle, mem_we = 0 and the address/data outputs are don't-care (drive 0).
REQ-031 Read latency SHALL be exactly 1 cycle: a read issued in cycle N asserts <owner>_rvalid in cycle N+1 with <owner>_rdata = mem_rdata.
REQ-032 A write SHALL never produce rvalid.
REQ-033 rvalid SHALL be routed using the FSM state; cpu_rvalid and ld_rvalid are never both high.
REQ-034 A non-granted requester is expected to hold its request stable; the arbiter SHALL not latch requests.
REQ-035 Misaligned access (granted, addr[1:0] != 0): misalign_err SHALL set the next cycle.
REQ-036 A misaligned write SHALL be suppressed (mem_we = 0); a misaligned read proceeds word-aligned.
REQ-037 boot deasserting mid-stream SHALL take effect the same cycle; a read return already in flight SHALL still be delivered to its owner.
REQ-038 Simultaneous cpu_req and ld_req with starve_cnt < STARVE_MAX SHALL grant the CPU, and cpu_stall = 0.

Reset
REQ-039 While rst is high at a clock edge: FSM -> IDLE, starve_cnt -> 0, cpu_rvalid = ld_rvalid = 0, cpu_rdata = ld_rdata = 0, misalign_err = 0.
REQ-040 While rst is high, grants SHALL be forced to 0, so mem_en = 0, cpu_stall = 0 and ld_gnt = 0.
REQ-041 Any read issued in the cycle before reset asserts SHALL be discarded; no rvalid after reset.

Verification
REQ-042 Reset 20 ns into a 100 ns clock -> all outputs 0 at the first edge; mem_en = 0 while rst = 1.
REQ-043 CPU read at 0x10, memory word 4 = 0xDEADBEEF -> mem_addr = 4 in cycle N; cpu_rvalid = 1 and cpu_rdata = 0xDEADBEEF in cycle N+1; ld_rvalid = 0.
REQ-044 cpu_req and ld_req both held high with STARVE_MAX = 3 -> CPU granted cycles 0-2, loader granted cycle 3 with cpu_stall = 1, CPU again cycle 4; pattern repeats.
REQ-045 boot = 1, loader writes 0x0000_0001..0x0000_0004 to 0x0..0xC while cpu_req = 1 -> four ld_gnt cycles, cpu_stall = 1 throughout, memory words 0..3 written.
REQ-046 CPU write to 0x13 -> mem_we = 0 that cycle, misalign_err = 1 the next cycle and stays 1 until rst.
REQ-047 Loader read issued, then rst asserted the next cycle -> ld_rvalid = 0 after the reset edge; FSM in IDLE.
